// File: rtl/down_counter_timer_pkg.sv
// down_counter_timer_pkg: shared state encoding and default sizing for the down-counter timer
package down_counter_timer_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_e;
  localparam int DEF_WIDTH    = 4;
  localparam int DEF_PRESCALE = 1;
endpackage

// File: rtl/down_counter_timer_tick_prescaler.sv
// tick_prescaler: emits one tick every PRESCALE enabled cycles; phase frozen while en is low
module tick_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int CW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  assign tick = en && cnt_q == CW'(PRESCALE - 1);
  always_comb cnt_d = clr ? '0 : !en ? cnt_q : tick ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk)
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
endmodule

// File: rtl/down_counter_timer.sv
// down_counter_timer: loadable prescaled down-counter with terminal-count pulse and optional auto-reload
module down_counter_timer
  import down_counter_timer_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d_in,
  input  logic             start,
  input  logic             stop,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] c_out,
  output logic             busy,
  output logic             tc,
  output logic             done
);
  state_e state_q, state_d;
  logic [WIDTH-1:0] c_q, c_d, reload_q, reload_d;
  logic busy_q, busy_d, tc_q, tc_d, done_q, done_d;
  logic tick, start_ok, pre_en, pre_clr;
  assign start_ok = start && !stop;
  assign pre_en   = state_q == ST_RUN && !load && !stop;
  assign pre_clr  = load || (start_ok && (state_q == ST_IDLE || state_q == ST_DONE));
  tick_prescaler #(.PRESCALE(PRESCALE)) u_pre (
    .clk (clk),
    .rst (rst),
    .en  (pre_en),
    .clr (pre_clr),
    .tick(tick)
  );
  always_comb begin
    state_d  = state_q;
    c_d      = c_q;
    reload_d = reload_q;
    busy_d   = busy_q;
    tc_d     = 1'b0;
    done_d   = done_q;
    if (load) begin
      c_d      = d_in;
      reload_d = d_in;
      state_d  = ST_IDLE;
      busy_d   = 1'b0;
      done_d   = 1'b0;
    end else begin
      case (state_q)
        ST_RUN:
          if (stop) state_d = ST_HOLD;
          else if (tick && c_q > WIDTH'(1)) c_d = c_q - 1'b1;
          else if (tick && c_q == WIDTH'(1)) begin
            tc_d    = 1'b1;
            c_d     = auto_reload ? reload_q : '0;
            state_d = auto_reload ? ST_RUN : ST_DONE;
            busy_d  = auto_reload;
            done_d  = !auto_reload;
          end
        ST_HOLD: if (start_ok) state_d = ST_RUN;
        ST_IDLE:
          if (start_ok) begin
            state_d = c_q != '0 ? ST_RUN : ST_DONE;
            busy_d  = c_q != '0;
            done_d  = c_q == '0;
          end
        default:
          if (start_ok && reload_q != '0) begin
            c_d     = reload_q;
            state_d = ST_RUN;
            busy_d  = 1'b1;
            done_d  = 1'b0;
          end
      endcase
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q  <= ST_IDLE;
      c_q      <= '0;
      reload_q <= '0;
      busy_q   <= 1'b0;
      tc_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      c_q      <= c_d;
      reload_q <= reload_d;
      busy_q   <= busy_d;
      tc_q     <= tc_d;
      done_q   <= done_d;
    end
  assign c_out = c_q;
  assign busy  = busy_q;
  assign tc    = tc_q;
  assign done  = done_q;
endmodule

// File: tb/tb_down_counter_timer.sv
// tb_down_counter_timer: random and directed stimulus on PRESCALE=1 and PRESCALE=4 instances vs a behavioural model
module tb_down_counter_timer;
  localparam int M_IDLE = 0, M_RUN = 1, M_HOLD = 2, M_DONE = 3;
  logic clk = 1'b0;
  logic rst, load, start, stop, auto_reload;
  logic [3:0] d_in;
  logic [3:0] c1, c4;
  logic busy1, busy4, tc1, tc4, done1, done4;
  int errors = 0, checks = 0;
  int mode [2], cnt [2], rl [2], ph [2], tcm [2];
  always #5 clk = ~clk;
  down_counter_timer #(.WIDTH(4), .PRESCALE(1)) u1 (
    .clk(clk), .rst(rst), .load(load), .d_in(d_in), .start(start), .stop(stop),
    .auto_reload(auto_reload), .c_out(c1), .busy(busy1), .tc(tc1), .done(done1)
  );
  down_counter_timer #(.WIDTH(4), .PRESCALE(4)) u4 (
    .clk(clk), .rst(rst), .load(load), .d_in(d_in), .start(start), .stop(stop),
    .auto_reload(auto_reload), .c_out(c4), .busy(busy4), .tc(tc4), .done(done4)
  );
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_step(input int k, input int p);
    bit tk;
    tcm[k] = 0;
    if (rst) begin
      mode[k] = M_IDLE; cnt[k] = 0; rl[k] = 0; ph[k] = 0;
    end else if (load) begin
      mode[k] = M_IDLE; cnt[k] = int'(d_in); rl[k] = int'(d_in); ph[k] = 0;
    end else if (mode[k] == M_RUN && stop) mode[k] = M_HOLD;
    else if (mode[k] == M_RUN) begin
      tk = ph[k] == p - 1;
      ph[k] = (ph[k] + 1) % p;
      if (tk && cnt[k] > 1) cnt[k]--;
      else if (tk && cnt[k] == 1) begin
        tcm[k] = 1;
        if (auto_reload) cnt[k] = rl[k];
        else begin cnt[k] = 0; mode[k] = M_DONE; end
      end
    end else if (start && !stop) begin
      if (mode[k] == M_IDLE) begin
        ph[k] = 0; mode[k] = cnt[k] != 0 ? M_RUN : M_DONE;
      end else if (mode[k] == M_HOLD) mode[k] = M_RUN;
      else if (rl[k] != 0) begin
        cnt[k] = rl[k]; ph[k] = 0; mode[k] = M_RUN;
      end
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    model_step(0, 1);
    model_step(1, 4);
    #1;
    check("p1.c_out", int'(c1), cnt[0]);
    check("p1.busy", int'(busy1), int'(mode[0] == M_RUN || mode[0] == M_HOLD));
    check("p1.tc", int'(tc1), tcm[0]);
    check("p1.done", int'(done1), int'(mode[0] == M_DONE));
    check("p4.c_out", int'(c4), cnt[1]);
    check("p4.busy", int'(busy4), int'(mode[1] == M_RUN || mode[1] == M_HOLD));
    check("p4.tc", int'(tc4), tcm[1]);
    check("p4.done", int'(done4), int'(mode[1] == M_DONE));
  endtask
  task automatic drive(input bit r, input bit l, input int d, input bit s, input bit p);
    rst = r; load = l; d_in = 4'(d); start = s; stop = p;
    cyc();
    rst = 0; load = 0; start = 0; stop = 0;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask
  initial begin
    rst = 1; load = 0; start = 0; stop = 0; auto_reload = 0; d_in = 0;
    for (int k = 0; k < 2; k++) begin mode[k] = M_IDLE; cnt[k] = 0; rl[k] = 0; ph[k] = 0; tcm[k] = 0; end
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    check("reset.c_out", int'(c1), 0);
    drive(0, 0, 0, 1, 0);
    check("zero_start.done", int'(done1), 1);
    idle(3);
    drive(0, 1, 5, 0, 0);
    drive(0, 0, 0, 1, 0);
    idle(8);
    check("oneshot.final", int'(c1), 0);
    auto_reload = 1;
    drive(0, 1, 3, 0, 0);
    drive(0, 0, 0, 1, 0);
    idle(14);
    auto_reload = 0;
    drive(0, 1, 2, 0, 0);
    drive(0, 0, 0, 1, 0);
    idle(12);
    drive(0, 1, 5, 0, 0);
    drive(0, 0, 0, 1, 0);
    idle(9);
    drive(0, 0, 0, 0, 1);
    idle(10);
    check("hold.c_out", int'(c4), 3);
    drive(0, 0, 0, 1, 0);
    idle(16);
    drive(0, 1, 6, 0, 0);
    drive(0, 0, 0, 1, 0);
    idle(2);
    drive(0, 1, 9, 0, 0);
    check("load_in_run.busy", int'(busy1), 0);
    drive(1, 1, 7, 0, 0);
    check("rst_over_load", int'(c4), 0);
    drive(0, 1, 8, 0, 0);
    drive(0, 0, 0, 1, 0);
    idle(2);
    drive(0, 0, 0, 1, 1);
    idle(3);
    drive(0, 0, 0, 1, 0);
    idle(4);
    drive(0, 1, 15, 0, 0);
    drive(0, 0, 0, 1, 0);
    idle(20);
    check("no_wrap", int'(c1), 0);
    drive(0, 0, 0, 1, 0);
    check("done_restart", int'(c1), 15);
    idle(5);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) auto_reload = ~auto_reload;
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 14) == 0, int'($urandom_range(0, 15)),
            $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
